// File: rtl/aes_out_serializer.sv
// ---------------------------------------------------------------------------
// aes_out_serializer
//
// Purpose:
//   Sits downstream of AES_top. Each 128-bit result strobed on
//   AES_data_out_valid is captured into a small block FIFO (FIFO_DEPTH
//   entries). The head block is streamed out as four 32-bit words, most
//   significant word first, over a valid/ready handshake.
//
// Ports:
//   AES_clk             in   1      clock, rising edge
//   AES_rst             in   1      synchronous, active-high reset
//   AES_data_out_valid  in   1      1-cycle strobe, AES_data_out is a result
//   AES_data_out        in   128    ciphertext block
//   ser_word            out  32     current output word (registered)
//   ser_valid           out  1      ser_word is valid (registered)
//   ser_ready           in   1      consumer accepts ser_word
//   ser_last            out  1      ser_word is the last word of its block
//   blk_level           out  LVL_W  number of blocks stored (0..FIFO_DEPTH)
//   overflow            out  1      sticky, a block was dropped on a full FIFO
//   ser_parity          out  1      even parity of ser_word (only with
//                                   AES_OUT_SER_PARITY_EN)
//   dbg_state           out  3      per-block word FSM state, for debug
//
// Handshake: a word transfers on a rising edge where ser_valid and ser_ready
//   are both 1. While ser_valid is 1 and ser_ready is 0, ser_word, ser_valid
//   and ser_last hold. ser_valid never drops without a transfer except on
//   reset. ser_ready is ignored while ser_valid is 0.
//
// Configuration macro:
//   AES_OUT_SER_PARITY_EN  adds the ser_parity output and its register.
// ---------------------------------------------------------------------------
module aes_out_serializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic             AES_clk,
  input  logic             AES_rst,
  input  logic             AES_data_out_valid,
  input  logic [127:0]     AES_data_out,
  output logic [31:0]      ser_word,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic [LVL_W-1:0] blk_level,
  output logic             overflow,
`ifdef AES_OUT_SER_PARITY_EN
  output logic             ser_parity,
`endif
  output logic [2:0]       dbg_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Word-position FSM for the head block. IDLE means the FIFO is empty.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W0   = 3'd1,
    ST_W1   = 3'd2,
    ST_W2   = 3'd3,
    ST_W3   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               overflow_q, overflow_d;
  logic [31:0]        ser_word_q, ser_word_d;
  logic               ser_valid_q, ser_valid_d;
  logic               ser_last_q, ser_last_d;
  logic [127:0]       mem_q [FIFO_DEPTH];

  logic               xfer;
  logic               pop;
  logic               full;
  logic               push;
  logic [127:0]       head_blk;
  logic [1:0]         idx_d;

  function automatic logic [31:0] word_sel(input logic [127:0] blk,
                                           input logic [1:0]   idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

  function automatic logic [1:0] state_idx(input state_e s);
    logic [1:0] i;
    case (s)
      ST_W1:   i = 2'd1;
      ST_W2:   i = 2'd2;
      ST_W3:   i = 2'd3;
      default: i = 2'd0;
    endcase
    return i;
  endfunction

  always_comb begin
    xfer       = ser_valid_q & ser_ready;
    pop        = xfer & (state_q == ST_W3);
    full       = (level_q == LVL_W'(FIFO_DEPTH));
    // A pop on the same edge frees the slot a full FIFO would otherwise lack.
    push       = AES_data_out_valid & (~full | pop);

    overflow_d = overflow_q | (AES_data_out_valid & ~push);
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    state_d = state_q;
    if (level_d == '0) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_W0;
        ST_W0:   if (xfer) state_d = ST_W1;
        ST_W1:   if (xfer) state_d = ST_W2;
        ST_W2:   if (xfer) state_d = ST_W3;
        ST_W3:   if (xfer) state_d = ST_W0;
        default: state_d = ST_IDLE;
      endcase
    end
    idx_d = state_idx(state_d);

    // The next head block may be the one written on this very edge (empty
    // FIFO, or a single block replaced by a same-edge push), so bypass it.
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_blk = AES_data_out;
    end else begin
      head_blk = mem_q[rd_ptr_d];
    end

    ser_valid_d = (level_d != '0);
    ser_word_d  = ser_valid_d ? word_sel(head_blk, idx_d) : 32'd0;
    ser_last_d  = ser_valid_d & (state_d == ST_W3);
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      ser_word_q  <= 32'd0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      ser_word_q  <= ser_word_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge AES_clk) begin
    if (!AES_rst && push) begin
      mem_q[wr_ptr_q] <= AES_data_out;
    end
  end

`ifdef AES_OUT_SER_PARITY_EN
  logic ser_parity_q, ser_parity_d;

  always_comb begin
    ser_parity_d = ^ser_word_d;
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      ser_parity_q <= 1'b0;
    end else begin
      ser_parity_q <= ser_parity_d;
    end
  end

  assign ser_parity = ser_parity_q;
`endif

  assign ser_word  = ser_word_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;
  assign blk_level = level_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_out_serializer.sv
// ---------------------------------------------------------------------------
// tb_aes_out_serializer
//
// Bench for aes_out_serializer. A reference model holds the stored blocks as
// a queue plus a word index and a sticky overflow flag. It is updated at each
// rising edge from the inputs present at that edge, and every DUT output is
// compared 1 ns later. Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_aes_out_serializer;

  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [127:0]  in_data;
  logic [31:0]   ser_word;
  logic          ser_valid;
  logic          ready;
  logic          ser_last;
  logic [LW-1:0] blk_level;
  logic          overflow;
  logic [2:0]    dbg_state;
`ifdef AES_OUT_SER_PARITY_EN
  logic          ser_parity;
`endif

  aes_out_serializer #(.FIFO_DEPTH(DEPTH), .LVL_W(LW)) dut (
    .AES_clk            (clk),
    .AES_rst            (rst),
    .AES_data_out_valid (in_valid),
    .AES_data_out       (in_data),
    .ser_word           (ser_word),
    .ser_valid          (ser_valid),
    .ser_ready          (ready),
    .ser_last           (ser_last),
    .blk_level          (blk_level),
    .overflow           (overflow),
`ifdef AES_OUT_SER_PARITY_EN
    .ser_parity         (ser_parity),
`endif
    .dbg_state          (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  logic [127:0] exp_q[$];
  int           m_idx;
  logic         m_ovf;
  int           n_checks;
  int           n_fail;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit xfer;
    bit pop;
    bit full;
    if (rst) begin
      exp_q.delete();
      m_idx = 0;
      m_ovf = 1'b0;
    end else begin
      xfer = (exp_q.size() != 0) && ready;
      pop  = xfer && (m_idx == 3);
      full = (exp_q.size() == DEPTH);
      if (xfer) m_idx = (m_idx + 1) % 4;
      if (pop) void'(exp_q.pop_front());
      if (in_valid) begin
        if (!full || pop) exp_q.push_back(in_data);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic         v;
    logic [127:0] blk;
    logic [31:0]  w;
    v = (exp_q.size() != 0);
    w = 32'd0;
    if (v) begin
      blk = exp_q[0];
      w   = blk[(3 - m_idx) * 32 +: 32];
    end
    check("ser_valid", 128'(ser_valid), 128'(v));
    check("ser_word",  128'(ser_word),  128'(w));
    check("ser_last",  128'(ser_last),  128'(v && (m_idx == 3)));
    check("blk_level", 128'(blk_level), 128'(exp_q.size()));
    check("overflow",  128'(overflow),  128'(m_ovf));
`ifdef AES_OUT_SER_PARITY_EN
    check("ser_parity", 128'(ser_parity), 128'(^w));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic push_blk(input logic [127:0] d);
    in_valid = 1'b1; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  logic [127:0] fips;
  logic [31:0]  fips_w [4];

  initial begin
    n_checks = 0; n_fail = 0; m_idx = 0; m_ovf = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; ready = 1'b0;
    fips = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    fips_w[0] = 32'h69c4e0d8; fips_w[1] = 32'h6a7b0430;
    fips_w[2] = 32'hd8cdb780; fips_w[3] = 32'h70b4c55a;

    // Reset state
    step(); step();
    rst = 1'b0;
    check("rst_word", 128'(ser_word), 128'd0);
    check("rst_level", 128'(blk_level), 128'd0);

    // 1: FIPS vector, ready held high (no spurious transfer on push edge)
    ready = 1'b1;
    push_blk(fips);
    check("fips_w0", 128'(ser_word), 128'(fips_w[0]));
    for (int i = 1; i < 4; i++) begin
      step();
      check("fips_w", 128'(ser_word), 128'(fips_w[i]));
      check("fips_last", 128'(ser_last), 128'(i == 3));
    end
    step();
    check("fips_empty", 128'(ser_valid), 128'd0);

    // 2: backpressure
    ready = 1'b0;
    push_blk(fips);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold", 128'(ser_word), 128'(fips_w[0]));
    end
    ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      check("bp_w", 128'(ser_word), 128'(fips_w[i]));
    end
    step();
    check("bp_empty", 128'(ser_valid), 128'd0);

    // 3: fill with overflow
    ready = 1'b0;
    for (int b = 1; b <= 5; b++) push_blk(128'(b));
    check("fill_level", 128'(blk_level), 128'd4);
    check("fill_ovf", 128'(overflow), 128'd1);
    ready = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      for (int w = 0; w < 4; w++) begin
        if (w == 3) check("fill_lsw", 128'(ser_word), 128'(b));
        step();
      end
    end
    check("fill_empty", 128'(ser_valid), 128'd0);
    do_reset();

    // 4: push on the word-3 handshake of a full FIFO
    ready = 1'b0;
    for (int b = 1; b <= 4; b++) push_blk(128'(b));
    ready = 1'b1;
    step(); step(); step();
    check("fp_at_w3", 128'(ser_last), 128'd1);
    push_blk(128'd6);
    check("fp_level", 128'(blk_level), 128'd4);
    check("fp_ovf", 128'(overflow), 128'd0);
    begin
      int exp_lsw [4];
      exp_lsw[0] = 2; exp_lsw[1] = 3; exp_lsw[2] = 4; exp_lsw[3] = 6;
      for (int b = 0; b < 4; b++) begin
        for (int w = 0; w < 4; w++) begin
          if (w == 3) check("fp_lsw", 128'(ser_word), 128'(exp_lsw[b]));
          step();
        end
      end
    end
    check("fp_empty", 128'(ser_valid), 128'd0);

    // 5: reset mid-stream
    push_blk(fips);
    step();
    check("mr_w1", 128'(ser_word), 128'(fips_w[1]));
    push_blk(fips);
    do_reset();
    check("mr_valid", 128'(ser_valid), 128'd0);
    check("mr_level", 128'(blk_level), 128'd0);
    step();
    push_blk(fips);
    check("mr_restart", 128'(ser_word), 128'(fips_w[0]));
    step(); step(); step(); step();

`ifdef AES_OUT_SER_PARITY_EN
    // 6: parity
    ready = 1'b0;
    push_blk({32'h00000001, 32'h00000003, 64'd0});
    check("par_1", 128'(ser_parity), 128'd1);
    ready = 1'b1;
    step();
    check("par_3", 128'(ser_parity), 128'd0);
    ready = 1'b0;
`endif

    // Randomized run
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      in_valid = ($urandom_range(0, 99) < 40);
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      ready    = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 70 : 25));
      rst      = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
